weight_buffer_loader_18_9_42_2: RTL and testbench

Write-side companion of the 18-bit, 9-lane, 42-word, 2-bank weight buffer. It accepts a stream of 18-bit weights over a valid/ready handshake and packs 9 weights into each 162-bit word. It writes the words into the two bank RAMs at the addresses the buffer's read side uses: bank 0 at 0..41, bank 1 at 42..83. It sits between the weight DMA/host stream and the `single_port_ram` instances, and it runs before inference begins.

---
 rtl/weight_loader_pkg.sv | 23 ++
 rtl/weight_word_packer.sv | 47 ++++
 rtl/weight_buffer_loader_18_9_42_2.sv | 102 ++++++++++
 tb/tb_weight_buffer_loader_18_9_42_2.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/weight_loader_pkg.sv
// Shared constants and FSM state type for the 18-bit x 9-lane x 42-word x 2-bank
// weight buffer loader.
package weight_loader_pkg;

   localparam int DATA_WIDTH    = 18;
   localparam int LANES         = 9;
   localparam int DEPTH         = 42;
   localparam int NUM_BANKS     = 2;
   localparam int ADDR_WIDTH    = 12;
   localparam int WORD_WIDTH    = DATA_WIDTH * LANES;
   localparam int TOTAL_WEIGHTS = LANES * DEPTH * NUM_BANKS;

   localparam int LANE_CNT_W = $clog2(LANES);
   localparam int WORD_CNT_W = $clog2(DEPTH);
   localparam int BANK_CNT_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/weight_word_packer.sv
// Collects LANES accepted weights into one word; word_valid pulses for one cycle
// after the accept that fills the last lane, with the finished word alongside.
module weight_word_packer
   import weight_loader_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic                  accept,
   input  logic [DATA_WIDTH-1:0] data,
   output logic                  last_lane,
   output logic                  word_valid,
   output logic [WORD_WIDTH-1:0] word
);

   logic [LANES-1:0][DATA_WIDTH-1:0] lanes;
   logic [LANE_CNT_W-1:0]            lane;

   assign last_lane = (lane == LANE_CNT_W'(LANES - 1));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         lane       <= '0;
         lanes      <= '0;
         word_valid <= 1'b0;
         word       <= '0;
      end else if (clear) begin
         lane       <= '0;
         lanes      <= '0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= 1'b0;
         if (accept) begin
            lanes[lane] <= data;
            if (last_lane) begin
               lane       <= '0;
               word_valid <= 1'b1;
               // the final lane is taken straight from the input so packing never stalls
               word       <= {data, lanes[LANES-2:0]};
            end else begin
               lane <= lane + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/weight_buffer_loader_18_9_42_2.sv
// Weight buffer write-side loader: FSM, word/bank counters, address and write strobes.
// Optional WEIGHT_LOADER_CHECKSUM_EN builds a running sum of accepted weights.
module weight_buffer_loader_18_9_42_2
   import weight_loader_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [WORD_WIDTH-1:0] ram_data,
   output logic                  ram_we_0,
   output logic                  ram_we_1,
   output logic                  busy,
   output logic                  done,
   output logic [31:0]           checksum
);

   state_t                state, next_state;
   logic [WORD_CNT_W-1:0] word;
   logic [BANK_CNT_W-1:0] bank;
   logic [BANK_CNT_W-1:0] wr_bank;
   logic                  accept, clear, last_lane, final_word, word_valid;
   logic [ADDR_WIDTH-1:0] addr_next;

   assign in_ready   = (state == LOAD);
   assign busy       = (state == LOAD);
   assign done       = (state == DONE);
   assign accept     = in_valid && in_ready;
   assign clear      = start && (state != LOAD);
   assign final_word = (bank == BANK_CNT_W'(NUM_BANKS - 1)) && (word == WORD_CNT_W'(DEPTH - 1));
   assign addr_next  = ADDR_WIDTH'(bank) * ADDR_WIDTH'(DEPTH) + ADDR_WIDTH'(word);

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = LOAD;
         LOAD:    if (accept && last_lane && final_word) next_state = DONE;
         DONE:    if (start) next_state = LOAD;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= IDLE;
         word     <= '0;
         bank     <= '0;
         wr_bank  <= '0;
         ram_addr <= '0;
      end else begin
         state <= next_state;
         if (clear) begin
            word <= '0;
            bank <= '0;
         end else if (accept && last_lane) begin
            // address and bank are captured on the same edge the packer registers the word
            ram_addr <= addr_next;
            wr_bank  <= bank;
            if (word == WORD_CNT_W'(DEPTH - 1)) begin
               word <= '0;
               bank <= bank + 1'b1;
            end else begin
               word <= word + 1'b1;
            end
         end
      end
   end

   weight_word_packer u_packer (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear      (clear),
      .accept     (accept),
      .data       (in_data),
      .last_lane  (last_lane),
      .word_valid (word_valid),
      .word       (ram_data)
   );

   assign ram_we_0 = word_valid && (wr_bank == BANK_CNT_W'(0));
   assign ram_we_1 = word_valid && (wr_bank == BANK_CNT_W'(1));

`ifdef WEIGHT_LOADER_CHECKSUM_EN
   logic [31:0] sum;

   always_ff @(posedge clk) begin
      if (!reset_n || clear) begin
         sum <= '0;
      end else if (accept) begin
         sum <= sum + {{(32 - DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data};
      end
   end

   assign checksum = sum;
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_weight_buffer_loader_18_9_42_2.sv
// Directed bench for weight_buffer_loader_18_9_42_2: table of full loads plus reset/start corner cases.
module tb_weight_buffer_loader_18_9_42_2;

   logic         clk = 1'b0;
   logic         reset_n, start, in_valid;
   logic [17:0]  in_data;
   logic         in_ready, ram_we_0, ram_we_1, busy, done;
   logic [11:0]  ram_addr;
   logic [161:0] ram_data;
   logic [31:0]  checksum;

   weight_buffer_loader_18_9_42_2 dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .ram_addr (ram_addr),
      .ram_data (ram_data),
      .ram_we_0 (ram_we_0),
      .ram_we_1 (ram_we_1),
      .busy     (busy),
      .done     (done),
      .checksum (checksum)
   );

   always #5 clk = ~clk;

`ifdef WEIGHT_LOADER_CHECKSUM_EN
   localparam bit CS_EN = 1'b1;
`else
   localparam bit CS_EN = 1'b0;
`endif

   typedef struct {
      int          pat;
      int          gap;
      int          start_at;
      logic [31:0] cs;
   } vec_t;

   vec_t tbl[5];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cur_pat = 0;
   int   exp_idx = 0;
   int   wr_limit = 0;

   task automatic chk(input string name, input logic [161:0] act, input logic [161:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [17:0] weight(input int pat, input int i);
      case (pat)
         0:       return 18'(i);
         1:       return (i % 2 == 0) ? 18'h3FFFF : 18'h00001;
         default: return 18'h3FFFF;
      endcase
   endfunction

   function automatic logic [161:0] word_of(input int pat, input int k);
      logic [161:0] w;
      w = '0;
      for (int j = 0; j < 9; j++) w[18*j +: 18] = weight(pat, 9*k + j);
      return w;
   endfunction

   task automatic check_writes();
      if (ram_we_0 && ram_we_1) chk("we_exclusive", 2'b11, 2'b00);
      if (ram_we_0 || ram_we_1) begin
         if (exp_idx >= wr_limit) begin
            chk("unexpected_write", 1'b1, 1'b0);
         end else begin
            chk("we_bank", {ram_we_1, ram_we_0}, (exp_idx >= 42) ? 2'b10 : 2'b01);
            chk("wr_addr", ram_addr, 12'(exp_idx));
            chk("wr_data", ram_data, word_of(cur_pat, exp_idx));
            chk("done_with_strobe", done, exp_idx == 83);
         end
         exp_idx++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      check_writes();
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_in_ready"}, in_ready, 1'b0);
      chk({tag, "_addr"}, ram_addr, 12'd0);
      chk({tag, "_data"}, ram_data, '0);
      chk({tag, "_we"}, {ram_we_1, ram_we_0}, 2'b00);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_checksum"}, checksum, 32'd0);
   endtask

   task automatic run_load(input int pat, input int gap, input int start_at,
                           input logic [31:0] exp_cs, input bit prev_done);
      int  i, budget;
      bit  v, acc;
      cur_pat  = pat;
      exp_idx  = 0;
      wr_limit = 84;
      if (prev_done) chk("done_before_start", done, 1'b1);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("ready_after_start", in_ready, 1'b1);
      chk("done_cleared", done, 1'b0);
      chk("busy_in_load", busy, 1'b1);
      i = 0;
      budget = 0;
      while (exp_idx < 84 && budget < 3000) begin
         v        = (i < 756) && ($urandom_range(99) >= gap);
         in_valid = v;
         in_data  = weight(pat, i);
         start    = (start_at >= 0 && i == start_at);
         acc      = v && in_ready;
         tick();
         if (acc) i++;
         budget++;
      end
      start    = 1'b0;
      in_valid = 1'b0;
      chk("write_count", 162'(exp_idx), 162'(84));
      chk("accepted", 162'(i), 162'(756));
      chk("done_final", done, 1'b1);
      chk("ready_final", in_ready, 1'b0);
      chk("busy_final", busy, 1'b0);
      chk("checksum", checksum, exp_cs);
      in_valid = 1'b1;
      in_data  = 18'h12345;
      repeat (5) tick();
      in_valid = 1'b0;
      chk("checksum_hold", checksum, exp_cs);
      chk("done_hold", done, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{pat: 0, gap: 0,  start_at: -1,  cs: CS_EN ? 32'h00045ACE : 32'd0};
      tbl[1] = '{pat: 0, gap: 30, start_at: -1,  cs: CS_EN ? 32'h00045ACE : 32'd0};
      tbl[2] = '{pat: 0, gap: 0,  start_at: 100, cs: CS_EN ? 32'h00045ACE : 32'd0};
      tbl[3] = '{pat: 1, gap: 0,  start_at: -1,  cs: 32'd0};
      tbl[4] = '{pat: 2, gap: 20, start_at: -1,  cs: CS_EN ? 32'hFFFFFD0C : 32'd0};

      reset_n  = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      wr_limit = 0;
      repeat (3) tick();
      reset_checks("rst");
      reset_n = 1'b1;
      in_valid = 1'b1;
      repeat (3) tick();
      in_valid = 1'b0;
      chk("idle_ignores_valid", busy, 1'b0);
      chk("idle_checksum", checksum, 32'd0);

      for (int t = 0; t < 5; t++)
         run_load(tbl[t].pat, tbl[t].gap, tbl[t].start_at, tbl[t].cs, t > 0);

      // reset after 50 weights: five words written, the sixth is discarded
      cur_pat  = 0;
      exp_idx  = 0;
      wr_limit = 5;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 0; n < 50; n++) begin
         in_valid = 1'b1;
         in_data  = weight(0, n);
         tick();
      end
      in_valid = 1'b0;
      tick();
      chk("partial_writes", 162'(exp_idx), 162'(5));
      chk("partial_checksum", checksum, CS_EN ? 32'd1225 : 32'd0);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      reset_checks("midrst");
      repeat (4) tick();
      chk("midrst_writes", 162'(exp_idx), 162'(5));
      run_load(0, 0, -1, CS_EN ? 32'h00045ACE : 32'd0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
